// File: rtl/async_fifo_core_if.sv
// rtl/async_fifo_core_if.sv - write/read handshake bundle for the FIFO core
interface fifo_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  full,
        input  rd_data,
        input  empty
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output full,
        output rd_data,
        output empty
    );
endinterface

// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - single-clock FIFO core with registered read port
module async_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic wr_fire;
    logic rd_fire;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    assign wr_fire = bus.wr_en && !full;
    assign rd_fire = bus.rd_en && !empty;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
        if (wr_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_data_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            rptr_d    = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage carries no reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (wr_fire && rst_n) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - scoreboard bench for async_fifo_core
module tb_async_fifo_core;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    fifo_if #(.DATA_WIDTH(DW)) bus ();

    async_fifo_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] last_rd = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the DUT after every edge against the reference state.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rd = '0;
            chk("rst_empty", int'(bus.empty), 1);
            chk("rst_full", int'(bus.full), 0);
            chk("rst_rd_data", int'(bus.rd_data), 0);
        end else begin
            if (exp_q.size() > 0) begin
                last_rd = exp_q.pop_front();
                chk("rd_data", int'(bus.rd_data), int'(last_rd));
            end else begin
                chk("rd_data_hold", int'(bus.rd_data), int'(last_rd));
            end
            chk("empty", int'(bus.empty), int'(model_q.size() == 0));
            chk("full", int'(bus.full), int'(model_q.size() == DEPTH));
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] wd, input bit r);
        bit wf;
        bit rf;
        bus.wr_en   = w;
        bus.wr_data = wd;
        bus.rd_en   = r;
        @(posedge clk);
        #1;
        wf = w && (model_q.size() < DEPTH);
        rf = r && (model_q.size() > 0);
        if (rf) exp_q.push_back(model_q.pop_front());
        if (wf) model_q.push_back(wd);
        @(negedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = model_q.size();
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    logic [DW-1:0] order_words [8];

    initial begin
        order_words = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        rst_n       = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_now_empty", int'(bus.empty), 1);
        chk("reset_now_full", int'(bus.full), 0);
        chk("reset_now_rd_data", int'(bus.rd_data), 0);
        #48;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_empty", int'(bus.empty), 1);

        for (int i = 0; i < 8; i++) step(1'b1, order_words[i], 1'b0);
        drain();
        chk("order_empty", int'(bus.empty), 1);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        chk("full_after_16", int'(bus.full), 1);
        step(1'b1, 8'hFF, 1'b0);
        chk("full_after_overflow", int'(bus.full), 1);
        drain();
        chk("drain_empty", int'(bus.empty), 1);

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("underflow_hold", int'(bus.rd_data), 8'h0F);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'hA5, 1'b1);
        chk("simul_empty_empty", int'(bus.empty), 0);
        chk("simul_empty_rd_hold", int'(bus.rd_data), 8'h3C);
        step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("simul_full_full", int'(bus.full), 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45));
        end
        drain();

        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        exp_q.delete();
        #1;
        chk("midrst_empty", int'(bus.empty), 1);
        chk("midrst_full", int'(bus.full), 0);
        chk("midrst_rd_data", int'(bus.rd_data), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("after_rst_data", int'(bus.rd_data), 8'h77);
        chk("after_rst_empty", int'(bus.empty), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
